// File: rtl/bk_result_checker.sv
// bk_result_checker
// Response checker for the Brent-Kung adder. Golden sums for each operand
// triple are queued in an expected-result FIFO and compared, in order,
// against the adder results returned on the response side. Keeps check and
// error counts, captures the first failing vector and reports pass/fail.
module bk_result_checker #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic             i_stop,
   input  logic             i_stim_valid,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
   input  logic             i_res_valid,
   input  logic [WIDTH-1:0] i_sum,
   input  logic             i_cout,
   output logic [15:0]      o_chk_count,
   output logic [15:0]      o_err_count,
   output logic [WIDTH:0]   o_fail_exp,
   output logic [WIDTH:0]   o_fail_act,
   output logic             o_ovf,
   output logic             o_udf,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_pass
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t         r_state;
   state_t         w_state_next;

   logic [WIDTH:0] r_mem [DEPTH];
   logic [AW:0]    r_wr_ptr;
   logic [AW:0]    r_rd_ptr;
   logic [AW:0]    w_count;
   logic           w_empty;
   logic           w_full;
   logic           w_empty_next;
   logic [WIDTH:0] w_head;
   logic [WIDTH:0] w_golden;
   logic [WIDTH:0] w_actual;

   logic           w_in_run;
   logic           w_in_pop_state;
   logic           w_push_req;
   logic           w_pop_req;
   logic           w_push;
   logic           w_pop;
   logic           w_ovf_ev;
   logic           w_udf_ev;
   logic           w_mismatch;
   logic           w_err_inc;
   logic [15:0]    w_err_next;
   logic           w_ovf_next;

   logic [15:0]    r_chk_count;
   logic [15:0]    r_err_count;
   logic [WIDTH:0] r_fail_exp;
   logic [WIDTH:0] r_fail_act;
   logic           r_fail_seen;
   logic           r_ovf;
   logic           r_udf;
   logic           r_busy;
   logic           r_done;
   logic           r_pass;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign w_count  = r_wr_ptr - r_rd_ptr;
   assign w_empty  = (r_wr_ptr == r_rd_ptr);
   assign w_full   = (r_wr_ptr == {~r_rd_ptr[AW], r_rd_ptr[AW-1:0]});
   assign w_head   = r_mem[r_rd_ptr[AW-1:0]];

   // Golden value keeps the carry as the MSB.
   assign w_golden = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};
   assign w_actual = {i_cout, i_sum};

   assign w_in_run       = (r_state == S_RUN);
   assign w_in_pop_state = (r_state == S_RUN) || (r_state == S_DRAIN);

   // A start pulse discards the traffic of its own cycle.
   assign w_push_req = i_stim_valid && w_in_run && !i_start;
   assign w_pop_req  = i_res_valid && w_in_pop_state && !i_start;

   // The pop side looks at the FIFO as it stands before the edge, so a
   // simultaneous pop frees a slot for the push even when full.
   assign w_pop    = w_pop_req && !w_empty;
   assign w_udf_ev = w_pop_req && w_empty;
   assign w_push   = w_push_req && (!w_full || w_pop);
   assign w_ovf_ev = w_push_req && w_full && !w_pop;

   assign w_mismatch = w_pop && (w_actual != w_head);
   assign w_err_inc  = w_mismatch || w_udf_ev;

   // Only used while draining, where no pushes can occur.
   assign w_empty_next = w_empty || ((w_count == (AW+1)'(1)) && w_pop);

   assign w_err_next = i_start ? 16'd0 :
                       (w_err_inc && (r_err_count != 16'hFFFF)) ? r_err_count + 16'd1 :
                       r_err_count;
   assign w_ovf_next = i_start ? 1'b0 : (r_ovf || w_ovf_ev);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; start takes priority over stop everywhere.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_start) w_state_next = S_RUN;
         end
         S_RUN: begin
            if (i_start) begin
               w_state_next = S_RUN;
            end else if (i_stop) begin
               w_state_next = (w_empty && !w_push) ? S_DONE : S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (i_start) begin
               w_state_next = S_RUN;
            end else if (w_empty_next) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            if (i_start) w_state_next = S_RUN;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Expected-result storage; contents need no reset, pointers gate validity.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= w_golden;
      end
   end

   // FIFO pointers, counters, sticky flags, first-failure capture and status.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_chk_count <= '0;
         r_err_count <= '0;
         r_fail_exp  <= '0;
         r_fail_act  <= '0;
         r_fail_seen <= 1'b0;
         r_ovf       <= 1'b0;
         r_udf       <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
      end else begin
         r_err_count <= w_err_next;
         r_ovf       <= w_ovf_next;
         r_busy      <= (w_state_next == S_RUN) || (w_state_next == S_DRAIN);
         r_done      <= (w_state_next == S_DONE);
         r_pass      <= (w_state_next == S_DONE) && (w_err_next == 16'd0) && !w_ovf_next;
         if (i_start) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_chk_count <= '0;
            r_fail_exp  <= '0;
            r_fail_act  <= '0;
            r_fail_seen <= 1'b0;
            r_udf       <= 1'b0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            if (w_pop && (r_chk_count != 16'hFFFF)) begin
               r_chk_count <= r_chk_count + 16'd1;
            end
            if (w_udf_ev) r_udf <= 1'b1;
            if (w_err_inc && !r_fail_seen) begin
               r_fail_seen <= 1'b1;
               r_fail_exp  <= w_udf_ev ? '0 : w_head;
               r_fail_act  <= w_actual;
            end
         end
      end
   end

   assign o_chk_count = r_chk_count;
   assign o_err_count = r_err_count;
   assign o_fail_exp  = r_fail_exp;
   assign o_fail_act  = r_fail_act;
   assign o_ovf       = r_ovf;
   assign o_udf       = r_udf;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_pass      = r_pass;

endmodule

// File: tb/tb_bk_result_checker.sv
// Directed testbench for bk_result_checker.
module tb_bk_result_checker;

   localparam int WIDTH = 16;
   localparam int DEPTH = 8;

   logic             clk;
   logic             rst_n;
   logic             i_start;
   logic             i_stop;
   logic             i_stim_valid;
   logic [WIDTH-1:0] i_a;
   logic [WIDTH-1:0] i_b;
   logic             i_cin;
   logic             i_res_valid;
   logic [WIDTH-1:0] i_sum;
   logic             i_cout;
   logic [15:0]      o_chk_count;
   logic [15:0]      o_err_count;
   logic [WIDTH:0]   o_fail_exp;
   logic [WIDTH:0]   o_fail_act;
   logic             o_ovf;
   logic             o_udf;
   logic             o_busy;
   logic             o_done;
   logic             o_pass;

   int checks = 0;
   int errors = 0;

   bk_result_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_stop(i_stop),
      .i_stim_valid(i_stim_valid), .i_a(i_a), .i_b(i_b), .i_cin(i_cin),
      .i_res_valid(i_res_valid), .i_sum(i_sum), .i_cout(i_cout),
      .o_chk_count(o_chk_count), .o_err_count(o_err_count),
      .o_fail_exp(o_fail_exp), .o_fail_act(o_fail_act),
      .o_ovf(o_ovf), .o_udf(o_udf), .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock cycle of stimulus; inputs change 1 time unit after the edge.
   task automatic cyc(input logic st, input logic sp, input logic sv,
                      input logic [15:0] a, input logic [15:0] b, input logic c,
                      input logic rv, input logic [15:0] s, input logic co);
      i_start = st; i_stop = sp; i_stim_valid = sv; i_a = a; i_b = b; i_cin = c;
      i_res_valid = rv; i_sum = s; i_cout = co;
      @(posedge clk); #1;
      i_start = 0; i_stop = 0; i_stim_valid = 0; i_a = 0; i_b = 0; i_cin = 0;
      i_res_valid = 0; i_sum = 0; i_cout = 0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #12;
      checks++; if ({o_chk_count, o_err_count} !== 32'd0) begin errors++; $display("FAIL reset_counts got %h want 0", {o_chk_count, o_err_count}); end
      checks++; if ({o_fail_exp, o_fail_act} !== 34'd0) begin errors++; $display("FAIL reset_fail got %h want 0", {o_fail_exp, o_fail_act}); end
      checks++; if ({o_ovf, o_udf, o_busy, o_done, o_pass} !== 5'd0) begin errors++; $display("FAIL reset_flags got %b want 00000", {o_ovf, o_udf, o_busy, o_done, o_pass}); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      $display("test_reset done");
   endtask

   task automatic test_basic;
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", o_busy); end
      cyc(0, 0, 1, 16'd45687, 16'd8457, 1, 0, 0, 0);
      cyc(0, 0, 1, 16'd65535, 16'd1, 0, 1, 16'd54145, 0);
      cyc(0, 0, 1, 16'd12345, 16'd12345, 0, 1, 16'd0, 1);
      cyc(0, 0, 0, 0, 0, 0, 1, 16'd24690, 0);
      cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (o_chk_count !== 16'd3) begin errors++; $display("FAIL basic_chk got %0d want 3", o_chk_count); end
      checks++; if (o_err_count !== 16'd0) begin errors++; $display("FAIL basic_err got %0d want 0", o_err_count); end
      checks++; if ({o_done, o_pass, o_busy} !== 3'b110) begin errors++; $display("FAIL basic_status got %b want 110", {o_done, o_pass, o_busy}); end
      $display("test_basic chk=%0d err=%0d pass=%b", o_chk_count, o_err_count, o_pass);
   endtask

   task automatic test_mismatch;
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 1, 16'd2514, 16'd58499, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 1, 16'd61013, 0);
      cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (o_err_count !== 16'd1) begin errors++; $display("FAIL mis_err got %0d want 1", o_err_count); end
      checks++; if (o_chk_count !== 16'd1) begin errors++; $display("FAIL mis_chk got %0d want 1", o_chk_count); end
      checks++; if (o_fail_exp !== 17'd61014) begin errors++; $display("FAIL mis_fail_exp got %0d want 61014", o_fail_exp); end
      checks++; if (o_fail_act !== 17'd61013) begin errors++; $display("FAIL mis_fail_act got %0d want 61013", o_fail_act); end
      checks++; if ({o_done, o_pass} !== 2'b10) begin errors++; $display("FAIL mis_status got %b want 10", {o_done, o_pass}); end
      $display("test_mismatch exp=%0d act=%0d", o_fail_exp, o_fail_act);
   endtask

   task automatic test_overflow;
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i <= DEPTH; i++) cyc(0, 0, 1, 16'(i + 1), 16'(i), 0, 0, 0, 0);
      checks++; if (o_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", o_ovf); end
      cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
      checks++; if ({o_busy, o_done} !== 2'b10) begin errors++; $display("FAIL ovf_drain got %b want 10", {o_busy, o_done}); end
      for (int i = 0; i < DEPTH; i++) cyc(0, 0, 0, 0, 0, 0, 1, 16'(2 * i + 1), 0);
      checks++; if (o_chk_count !== 16'(DEPTH)) begin errors++; $display("FAIL ovf_chk got %0d want %0d", o_chk_count, DEPTH); end
      checks++; if (o_err_count !== 16'd0) begin errors++; $display("FAIL ovf_err got %0d want 0", o_err_count); end
      checks++; if ({o_udf, o_done, o_pass} !== 3'b010) begin errors++; $display("FAIL ovf_status got %b want 010", {o_udf, o_done, o_pass}); end
      $display("test_overflow chk=%0d ovf=%b udf=%b", o_chk_count, o_ovf, o_udf);
   endtask

   task automatic test_underflow;
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 1, 16'd5, 0);
      checks++; if (o_udf !== 1'b1) begin errors++; $display("FAIL udf_flag got %b want 1", o_udf); end
      checks++; if (o_err_count !== 16'd1) begin errors++; $display("FAIL udf_err got %0d want 1", o_err_count); end
      checks++; if (o_chk_count !== 16'd0) begin errors++; $display("FAIL udf_chk got %0d want 0", o_chk_count); end
      checks++; if ({o_fail_exp, o_fail_act} !== {17'd0, 17'd5}) begin errors++; $display("FAIL udf_fail got %0d/%0d want 0/5", o_fail_exp, o_fail_act); end
      $display("test_underflow udf=%b err=%0d", o_udf, o_err_count);
   endtask

   task automatic test_back_to_back;
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < DEPTH; i++) cyc(0, 0, 1, 16'(i * 100), 16'd7, 1, 0, 0, 0);
      cyc(0, 0, 1, 16'd1000, 16'd2, 0, 1, 16'd8, 0);
      checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL b2b_ovf got %b want 0", o_ovf); end
      cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 1; i < DEPTH; i++) cyc(0, 0, 0, 0, 0, 0, 1, 16'(i * 100 + 8), 0);
      cyc(0, 0, 0, 0, 0, 0, 1, 16'd1002, 0);
      checks++; if (o_chk_count !== 16'(DEPTH + 1)) begin errors++; $display("FAIL b2b_chk got %0d want %0d", o_chk_count, DEPTH + 1); end
      checks++; if (o_err_count !== 16'd0) begin errors++; $display("FAIL b2b_err got %0d want 0", o_err_count); end
      checks++; if ({o_ovf, o_done, o_pass} !== 3'b011) begin errors++; $display("FAIL b2b_status got %b want 011", {o_ovf, o_done, o_pass}); end
      $display("test_back_to_back chk=%0d pass=%b", o_chk_count, o_pass);
   endtask

   task automatic test_reset_mid_drain;
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 16'(i), 16'd1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 1, 16'd1, 0);
      cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy got %b want 1", o_busy); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({o_chk_count, o_err_count, o_fail_exp, o_fail_act} !== 66'd0) begin errors++; $display("FAIL rst_mid_data got %h want 0", {o_chk_count, o_err_count, o_fail_exp, o_fail_act}); end
      checks++; if ({o_ovf, o_udf, o_busy, o_done, o_pass} !== 5'd0) begin errors++; $display("FAIL rst_mid_flags got %b want 00000", {o_ovf, o_udf, o_busy, o_done, o_pass}); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 1, 16'd8, 16'd7, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 1, 16'd16, 0);
      cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (o_chk_count !== 16'd1) begin errors++; $display("FAIL rst_post_chk got %0d want 1", o_chk_count); end
      checks++; if ({o_err_count, o_done, o_pass} !== {16'd0, 2'b11}) begin errors++; $display("FAIL rst_post_status got err=%0d done=%b pass=%b want 0 1 1", o_err_count, o_done, o_pass); end
      $display("test_reset_mid_drain chk=%0d pass=%b", o_chk_count, o_pass);
   endtask

   initial begin
      i_start = 0; i_stop = 0; i_stim_valid = 0; i_a = 0; i_b = 0; i_cin = 0;
      i_res_valid = 0; i_sum = 0; i_cout = 0;
      test_reset;
      test_basic;
      test_mismatch;
      test_overflow;
      test_underflow;
      test_back_to_back;
      test_reset_mid_drain;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bk_result_checker.md
# bk_result_checker

On-chip response checker for the 16-bit Brent-Kung adder. The block receives the same operand stream that drives the adder, computes the golden result, and queues it in an expected-result FIFO. It then compares each adder result returned on the response side, so the adder can be run back-to-back in hardware and signed off without a simulator. It counts checks and mismatches, captures the first failing vector, and reports a final pass/fail.

## Interface
- WIDTH, 16, operand/sum width
- DEPTH, 8, expected-FIFO entries (power of two, 2..32)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; clears counters/flags/FIFO, enters RUN
- stop  in  1  pulse; no further stimulus, drain then finish
- stim_valid  in  1  operand triple present this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- Cin  in  1  carry in
- res_valid  in  1  adder result present this cycle
- Sum  in  WIDTH  adder sum under test
- Cout  in  1  adder carry-out under test
- chk_count  out  16  results compared (saturates at 65535)
- err_count  out  16  mismatches plus underflows (saturates)
- fail_exp  out  WIDTH+1  {Cout,Sum} expected at first failure
- fail_act  out  WIDTH+1  {Cout,Sum} received at first failure
- ovf  out  1  sticky: stim_valid while FIFO full in RUN
- udf  out  1  sticky: res_valid while FIFO empty in RUN/DRAIN
- busy  out  1  state is RUN or DRAIN
- done  out  1  state is DONE
- pass  out  1  done & err_count==0 & !ovf

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset enters IDLE.
- IDLE -> RUN on start.
- RUN -> DRAIN on stop. If the FIFO is empty that cycle and there is no push, the transition is RUN -> DONE directly.
- DRAIN -> DONE on the edge where the FIFO becomes empty.
- DONE -> RUN on start. start in RUN/DRAIN restarts: clears everything and stays in RUN.
- Golden value: {Cout_exp,Sum_exp} = a + b + Cin, computed at WIDTH+1 bits with no truncation of the carry.
- Push: a stim_valid cycle in RUN with the FIFO not full writes the golden value.
  - stim_valid while full: the entry is dropped and ovf is set.
  - stim_valid in IDLE/DRAIN/DONE is ignored, with no flag.
- Pop: a res_valid cycle in RUN or DRAIN.
  - FIFO non-empty: pops the head, compares {Cout,Sum} to it, and increments chk_count.
  - On mismatch, err_count is also incremented.
  - FIFO empty: udf is set and err_count is incremented; chk_count is unchanged.
- First failure: the first mismatch since start latches fail_exp/fail_act. Later failures do not overwrite them.
  - An underflow as first failure latches fail_exp=0, fail_act={Cout,Sum}.
- Simultaneous push and pop:
  - Both take effect in the same cycle, including when the FIFO is full. The pop frees the slot, so no ovf is raised.
  - When the FIFO is empty, the pop side sees empty, so udf is raised; the push still happens.
- start in the same cycle as stim_valid/res_valid: the clear wins and that cycle's traffic is discarded.
- start and stop together: start wins.
- Counters saturate and never wrap.

## Timing
- Reset values: all counters, fail_exp, fail_act, ovf, udf, busy, done and pass are 0; FIFO pointers are 0.
- Result latency is unconstrained: results may arrive any number of cycles after their stimulus, provided order is preserved and at most DEPTH are outstanding.
- A same-cycle push then pop is illegal for a 0-latency adder. Pop compares the head as it stands before the clock edge.
  - For a combinational adder, the bench delays res_valid/Sum/Cout one cycle.
- All outputs are registered; counter and flag updates are visible one cycle after the qualifying input edge.
- done/pass assert in the cycle after the final pop or the stop-with-empty edge.
- Reset asserted mid-run: all state clears immediately, asynchronously. Synchronous operation resumes on the first edge after deassertion.

## Test plan
- Stimulus: start; push 45687+8457+1, 65535+1+0 and 12345+12345+0; return 54145/0, 0/1 and 24690/0 one cycle later each; then stop.
  - Required: chk=3, err=0, done, pass.
- Stimulus: push 2514+58499+1; return Sum=61013, Cout=0.
  - Required: err=1, fail_exp=61014 with carry 0, fail_act=61013, pass=0.
- Stimulus: push DEPTH+1 vectors with no results, then drain all DEPTH.
  - Required: ovf=1, chk=DEPTH, pass=0, no udf.
- Stimulus: res_valid while the FIFO is empty in RUN.
  - Required: udf=1, err=1, chk=0.
- Stimulus: with the FIFO full, push and pop in the same cycle, then drain.
  - Required: no ovf, chk=DEPTH+1, err=0.
- Stimulus: assert rst_n low mid-DRAIN, then start and one clean vector 8+7+1.
  - Required: all outputs 0 during reset; afterwards expected 16/0, chk=1, pass=1.
